// File: rtl/ram_access_arbiter_if.sv
// Bus bundle between two word-level masters, the arbiter and the SPI RAM command port.
// The master modport is the environment side (masters plus RAM); slave is the arbiter.
interface ram_access_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 req0;
  logic                 req1;
  logic                 we0;
  logic                 we1;
  logic [ADDR_SIZE-1:0] addr0;
  logic [ADDR_SIZE-1:0] addr1;
  logic [ADDR_SIZE-1:0] wdata0;
  logic [ADDR_SIZE-1:0] wdata1;
  logic                 ack0;
  logic                 ack1;
  logic [ADDR_SIZE-1:0] rdata0;
  logic [ADDR_SIZE-1:0] rdata1;
  logic                 err0;
  logic                 err1;
  logic [ADDR_SIZE+1:0] ram_din;
  logic                 ram_rx_valid;
  logic [ADDR_SIZE-1:0] ram_dout;
  logic                 ram_tx_valid;
  logic                 busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ram_dout, ram_tx_valid,
    input  ack0, ack1, rdata0, rdata1, err0, err1,
    input  ram_din, ram_rx_valid, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ram_dout, ram_tx_valid,
    output ack0, ack1, rdata0, rdata1, err0, err1,
    output ram_din, ram_rx_valid, busy
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin two-master arbiter that turns word requests into two-beat SPI RAM commands.
// Optional read timeout is enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_access_arbiter #(
  parameter int ADDR_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_access_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RD_WAIT,
    S_DONE
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sel;
  logic                 r_we;
  logic                 r_rr;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [ADDR_SIZE-1:0] r_wdata;
  logic [ADDR_SIZE-1:0] r_rdata0;
  logic [ADDR_SIZE-1:0] r_rdata1;
  logic                 w_any_req;
  logic                 w_winner;
  logic                 w_timeout;
  logic                 w_rd_exit;
  logic [ADDR_SIZE+1:0] w_din;
  logic                 w_rx_valid;
  logic                 w_ack0;
  logic                 w_ack1;

  assign w_any_req = bus.req0 | bus.req1;
  // A lone requester always wins; on a tie the round-robin pointer decides.
  assign w_winner  = (bus.req0 && bus.req1) ? r_rr : bus.req1;
  assign w_rd_exit = (r_state == S_RD_WAIT) && (bus.ram_tx_valid || w_timeout);

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err0;
  logic             r_err1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_DATA) begin
      r_cnt <= '0;
    end else if (r_state == S_RD_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry is the RD_WAIT cycle whose increment would reach TIMEOUT_CYCLES; tx_valid beats it.
  assign w_timeout = (r_state == S_RD_WAIT) && !bus.ram_tx_valid &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else if (w_rd_exit || (r_state == S_DATA && r_we)) begin
      if (r_sel) r_err1 <= w_timeout;
      else       r_err0 <= w_timeout;
    end
  end

  assign bus.err0 = r_err0;
  assign bus.err1 = r_err1;
`else
  assign w_timeout = 1'b0;
  assign bus.err0  = 1'b0;
  assign bus.err1  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_din       = '0;
    w_rx_valid  = 1'b0;
    w_ack0      = 1'b0;
    w_ack1      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_din       = {(r_we ? 2'b00 : 2'b10), r_addr};
        w_rx_valid  = 1'b1;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_din       = r_we ? {2'b01, r_wdata} : {2'b11, {ADDR_SIZE{1'b0}}};
        w_rx_valid  = 1'b1;
        w_state_nxt = r_we ? S_DONE : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (w_rd_exit) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_ack0      = ~r_sel;
        w_ack1      = r_sel;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel    <= 1'b0;
      r_we     <= 1'b0;
      r_rr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel   <= w_winner;
            r_we    <= w_winner ? bus.we1    : bus.we0;
            r_addr  <= w_winner ? bus.addr1  : bus.addr0;
            r_wdata <= w_winner ? bus.wdata1 : bus.wdata0;
          end
        end
        S_RD_WAIT: begin
          if (w_rd_exit) begin
            if (r_sel) r_rdata1 <= bus.ram_tx_valid ? bus.ram_dout : '0;
            else       r_rdata0 <= bus.ram_tx_valid ? bus.ram_dout : '0;
          end
        end
        S_DONE: r_rr <= ~r_sel;
        default: ;
      endcase
    end
  end

  assign bus.ram_din      = w_din;
  assign bus.ram_rx_valid = w_rx_valid;
  assign bus.ack0         = w_ack0;
  assign bus.ack1         = w_ack1;
  assign bus.rdata0       = r_rdata0;
  assign bus.rdata1       = r_rdata1;
  assign bus.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: reset, write, read, tie round-robin, read wait/timeout,
// and reset during a read. Inputs change and outputs are checked on the falling clock edge.
module tb_ram_access_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ram_access_arbiter_if #(.ADDR_SIZE(8)) bus ();

  ram_access_arbiter #(
    .ADDR_SIZE      (8),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},  32'(bus.busy), 32'h0);
    check({tag, " din"},   32'(bus.ram_din), 32'h0);
    check({tag, " rxv"},   32'(bus.ram_rx_valid), 32'h0);
    check({tag, " acks"},  32'({bus.ack1, bus.ack0}), 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0  = 1'b0; bus.we1  = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    bus.ram_dout = '0; bus.ram_tx_valid = 1'b0;

    // Reset state
    tick(); tick();
    check_idle_outputs("rst");
    check("rst rdata", 32'({bus.rdata1, bus.rdata0}), 32'h0);
    check("rst err",   32'({bus.err1, bus.err0}), 32'h0);
    rst = 1'b0;
    tick();
    check_idle_outputs("post_rst");

    // Write from master 0; its bus changes after grant must not leak into the command
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h3C; bus.wdata0 = 8'hA5;
    tick();
    check("wr addr beat", 32'(bus.ram_din), 32'h03C);
    check("wr addr rxv",  32'({bus.busy, bus.ram_rx_valid}), 32'h3);
    bus.we0 = 1'b0; bus.addr0 = 8'hFF; bus.wdata0 = 8'h00;
    tick();
    check("wr data beat", 32'(bus.ram_din), 32'h1A5);
    check("wr data rxv",  32'({bus.busy, bus.ram_rx_valid, bus.ack0}), 32'h6);
    tick();
    check("wr ack",       32'({bus.busy, bus.ack1, bus.ack0}), 32'h5);
    check("wr done din",  32'({bus.ram_rx_valid, bus.ram_din}), 32'h0);
    bus.req0 = 1'b0;
    tick();
    check_idle_outputs("wr idle");

    // Read by master 1; a tx_valid during the DATA beat must be ignored
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h3C;
    tick();
    check("rd addr beat", 32'(bus.ram_din), 32'h23C);
    tick();
    check("rd data beat", 32'({bus.ram_rx_valid, bus.ram_din}), 32'h700);
    bus.ram_tx_valid = 1'b1; bus.ram_dout = 8'hFF;
    tick();
    check("rd wait",      32'({bus.busy, bus.ram_rx_valid, bus.ram_din}), 32'h800);
    check("rd wait acks", 32'({bus.ack1, bus.ack0}), 32'h0);
    bus.ram_tx_valid = 1'b0;
    tick();
    check("rd still wait", 32'({bus.busy, bus.ack1, bus.ack0}), 32'h4);
    bus.ram_tx_valid = 1'b1; bus.ram_dout = 8'hA5;
    tick();
    bus.ram_tx_valid = 1'b0; bus.ram_dout = 8'h00;
    check("rd ack",    32'({bus.ack1, bus.ack0}), 32'h2);
    check("rd rdata1", 32'(bus.rdata1), 32'hA5);
    check("rd rdata0", 32'(bus.rdata0), 32'h00);
    check("rd err1",   32'(bus.err1), 32'h0);
    bus.req1 = 1'b0;
    tick();
    check_idle_outputs("rd idle");
    check("rd rdata1 held", 32'(bus.rdata1), 32'hA5);

    // Tie: both masters hold writes; pointer starts at master 0 -> order 0,1,0,1
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h11; bus.wdata0 = 8'h22;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h33; bus.wdata1 = 8'h44;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("tie%0d addr", k), 32'(bus.ram_din), (k % 2 == 0) ? 32'h011 : 32'h033);
      tick();
      check($sformatf("tie%0d data", k), 32'(bus.ram_din), (k % 2 == 0) ? 32'h122 : 32'h144);
      check($sformatf("tie%0d early ack", k), 32'({bus.ack1, bus.ack0}), 32'h0);
      tick();
      check($sformatf("tie%0d ack", k), 32'({bus.ack1, bus.ack0}), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      tick();
      check($sformatf("tie%0d idle", k), 32'({bus.busy, bus.ack1, bus.ack0}), 32'h0);
    end

    // Read by master 0 with the RAM never answering
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h5A;
    tick();
    check("to addr beat", 32'(bus.ram_din), 32'h25A);
    tick();
    check("to data beat", 32'(bus.ram_din), 32'h300);
`ifdef RAM_ARB_TIMEOUT_EN
    for (int c = 0; c < 15; c++) tick();
    check("to last wait", 32'({bus.busy, bus.ack0}), 32'h2);
    tick();
    check("to ack",   32'({bus.ack1, bus.ack0}), 32'h1);
    check("to err0",  32'(bus.err0), 32'h1);
    check("to rdata", 32'(bus.rdata0), 32'h00);
`else
    for (int c = 0; c < 20; c++) tick();
    check("nto waiting", 32'({bus.busy, bus.ack1, bus.ack0}), 32'h4);
    bus.ram_tx_valid = 1'b1; bus.ram_dout = 8'h77;
    tick();
    bus.ram_tx_valid = 1'b0; bus.ram_dout = 8'h00;
    check("nto ack",    32'({bus.ack1, bus.ack0}), 32'h1);
    check("nto rdata0", 32'(bus.rdata0), 32'h77);
    check("nto err0",   32'(bus.err0), 32'h0);
`endif
    check("to rdata1 kept", 32'(bus.rdata1), 32'hA5);
    bus.req0 = 1'b0;
    tick();
    check_idle_outputs("to idle");

    // Reset while master 1's read sits in RD_WAIT, req1 kept high across reset
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h42;
    tick();
    check("rr addr beat", 32'(bus.ram_din), 32'h242);
    tick();
    tick();
    check("rr in wait", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    tick();
    check_idle_outputs("rr rst1");
    check("rr rst rdata", 32'({bus.rdata1, bus.rdata0}), 32'h0);
    tick();
    check_idle_outputs("rr rst2");
    rst = 1'b0;
    tick();
    check("rr restart addr", 32'({bus.ram_rx_valid, bus.ram_din}), 32'h642);
    check("rr no stale ack", 32'({bus.ack1, bus.ack0}), 32'h0);
    tick();
    check("rr restart data", 32'(bus.ram_din), 32'h300);
    tick();
    bus.ram_tx_valid = 1'b1; bus.ram_dout = 8'h99;
    tick();
    bus.ram_tx_valid = 1'b0; bus.ram_dout = 8'h00;
    check("rr ack",    32'({bus.ack1, bus.ack0}), 32'h2);
    check("rr rdata1", 32'(bus.rdata1), 32'h99);
    bus.req1 = 1'b0;
    tick();
    check_idle_outputs("rr idle");
    tick();
    check("rr single ack", 32'({bus.ack1, bus.ack0}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
